// File: rtl/chunked_serial_adder_if.sv
// rtl/chunked_serial_adder_if.sv - request/result bundle for chunked_serial_adder (optional sub via CHUNKED_ADDER_SUB_EN)
interface chunked_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum;

    modport master (
`ifdef CHUNKED_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum
    );

    modport slave (
`ifdef CHUNKED_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle a+b+cin through one CHUNK-bit ripple slice
// Optional subtract mode enabled by the CHUNKED_ADDER_SUB_EN macro.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chunked_serial_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum_r;
    logic [CHUNK:0]   slice;
    logic             accept, last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    always_comb begin
        accept   = bus.start && (state == IDLE || state == DONE);
        last     = (cnt == LAST);
        slice    = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        // partial sum enters at the top; after NCH chunks the result is fully assembled
        res_next = WIDTH'({slice[CHUNK-1:0], res} >> CHUNK);
`ifdef CHUNKED_ADDER_SUB_EN
        b_load   = bus.sub ? ~bus.b : bus.b;
        c_load   = bus.sub | bus.cin;
`else
        b_load   = bus.b;
        c_load   = bus.cin;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last)   state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
        bus.sum  = sum_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum_r <= '0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> CHUNK;
            b_sh  <= b_sh >> CHUNK;
            res   <= res_next;
            carry <= slice[CHUNK];
            cnt   <= cnt + CW'(1);
            if (last) sum_r <= {slice[CHUNK], res_next};
        end
    end
endmodule
